// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier: FSM states,
// Booth select codes and the 8-bit carry-lookahead slice used by the sum path.
package booth_multiplier_pkg;

  localparam int WIDTH      = 32;
  localparam int HI_W       = WIDTH + 2;
  localparam int MULT_ITERS = WIDTH / 2;
  localparam int CNT_W      = $clog2(MULT_ITERS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    BOOTH_ZERO = 3'd0,
    BOOTH_P1   = 3'd1,
    BOOTH_P2   = 3'd2,
    BOOTH_N1   = 3'd3,
    BOOTH_N2   = 3'd4
  } booth_sel_e;

  function automatic booth_sel_e booth_select(input logic [2:0] bits);
    booth_sel_e sel;
    case (bits)
      3'b001, 3'b010: sel = BOOTH_P1;
      3'b011:         sel = BOOTH_P2;
      3'b100:         sel = BOOTH_N2;
      3'b101, 3'b110: sel = BOOTH_N1;
      default:        sel = BOOTH_ZERO;
    endcase
    return sel;
  endfunction

  // Each carry is a flat sum of generate/propagate products, not a ripple chain.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                      input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       acc;
    logic       pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = i; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Issue/result bundle between the execute-stage decoder and the multiplier.
interface booth_multiplier_if;
  import booth_multiplier_pkg::*;

  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps {lo[1:0], q_1} onto operand-select controls.
module booth_recode
  import booth_multiplier_pkg::*;
(
  input  logic [1:0] lo_i,
  input  logic       q_1_i,
  output logic       sel_2x_o,
  output logic       negate_o,
  output logic       zero_o
);

  booth_sel_e sel;

  always_comb begin
    sel      = booth_select({lo_i, q_1_i});
    sel_2x_o = (sel == BOOTH_P2) || (sel == BOOTH_N2);
    negate_o = (sel == BOOTH_N1) || (sel == BOOTH_N2);
    zero_o   = (sel == BOOTH_ZERO);
  end

endmodule

// File: rtl/booth_multiplier.sv
// Multi-cycle signed 32x32 radix-4 Booth multiplier: 16 iterations through a
// 34-bit carry-lookahead accumulator, low product word plus overflow flag.
module booth_multiplier
  import booth_multiplier_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  booth_multiplier_if.slave  mul
);

  localparam int SLICES = (HI_W + 7) / 8;
  localparam int PAD_W  = SLICES * 8;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q;
  logic [HI_W-1:0]    hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               q1_q, q1_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q, exc_d;
  logic               start_accept;
  logic               last_iter;

  logic               sel_2x, negate, zero;
  logic [HI_W-1:0]    m_ext, op_base, op;
  logic [PAD_W-1:0]   sum_a, sum_b, sum_s;
  logic [SLICES:0]    cy;
  logic [HI_W-1:0]    hi_sum;
  logic signed [HI_W+WIDTH:0] shifted;
  logic               unused_sum;

  assign start_accept = mul.ctrl_MULT && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter    = (count_q == CNT_W'(MULT_ITERS - 1));

  booth_recode u_recode (
    .lo_i     (lo_q[1:0]),
    .q_1_i    (q1_q),
    .sel_2x_o (sel_2x),
    .negate_o (negate),
    .zero_o   (zero)
  );

  // Subtraction = inverted operand with carry-in 1 into the slice chain.
  assign m_ext   = {{(HI_W-WIDTH){m_q[WIDTH-1]}}, m_q};
  assign op_base = zero ? '0 : (sel_2x ? (m_ext << 1) : m_ext);
  assign op      = negate ? ~op_base : op_base;

  assign sum_a = {{(PAD_W-HI_W){1'b0}}, hi_q};
  assign sum_b = {{(PAD_W-HI_W){1'b0}}, op};
  assign cy[0] = negate;

  genvar gi;
  generate
    for (gi = 0; gi < SLICES; gi++) begin : g_cla
      assign {cy[gi+1], sum_s[gi*8 +: 8]} = cla8(sum_a[gi*8 +: 8], sum_b[gi*8 +: 8], cy[gi]);
    end
  endgenerate

  assign hi_sum     = sum_s[HI_W-1:0];
  assign unused_sum = ^{sum_s[PAD_W-1:HI_W], cy[SLICES]};

  assign shifted = $signed({hi_sum, lo_q, q1_q}) >>> 2;
  assign hi_d    = shifted[HI_W+WIDTH:WIDTH+1];
  assign lo_d    = shifted[WIDTH:1];
  assign q1_d    = shifted[0];
  assign exc_d   = !((&{hi_d, lo_d[WIDTH-1]}) || !(|{hi_d, lo_d[WIDTH-1]}));

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul.ctrl_MULT) state_d = S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  state_d = mul.ctrl_MULT ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul.busy           = 1'b0;
    mul.data_resultRDY = 1'b0;
    case (state_q)
      S_RUN:   mul.busy = 1'b1;
      S_DONE:  mul.data_resultRDY = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      q1_q     <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (start_accept) begin
      m_q      <= mul.data_operandA;
      hi_q     <= '0;
      lo_q     <= mul.data_operandB;
      q1_q     <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (state_q == S_RUN) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q1_q    <= q1_d;
      count_q <= count_q + CNT_W'(1);
      if (last_iter) begin
        result_q <= lo_d;
        exc_q    <= exc_d;
      end
    end
  end

  assign mul.data_result    = result_q;
  assign mul.data_exception = exc_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier: latency, products, overflow,
// ignored re-issue, reset abort and back-to-back issue.
module tb_booth_multiplier;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  booth_multiplier_if mul_if ();

  booth_multiplier dut (
    .clock (clk),
    .reset (rst),
    .mul   (mul_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    mul_if.ctrl_MULT     = 1'b1;
    mul_if.data_operandA = a;
    mul_if.data_operandB = b;
  endtask

  // Called just after a negedge with ctrl_MULT already raised; returns the
  // number of cycles until RDY (41 on timeout).
  task automatic wait_rdy(input string tag, input int repulse_at, output int n);
    n = 0;
    while (n < 41) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mul_if.ctrl_MULT     = 1'b0;
        mul_if.data_operandA = $urandom;
        mul_if.data_operandB = $urandom;
        check_eq({tag, " busy"}, 32'(mul_if.busy), 32'd1);
      end
      if (repulse_at != 0 && n == repulse_at) issue(32'd5, 32'd5);
      if (repulse_at != 0 && n == repulse_at + 1) mul_if.ctrl_MULT = 1'b0;
      if (mul_if.data_resultRDY) break;
    end
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int n;
    @(negedge clk);
    issue(a, b);
    wait_rdy(tag, 0, n);
    check_eq({tag, " latency"}, 32'(n), 32'd17);
    check_eq({tag, " result"}, mul_if.data_result, exp_res);
    check_eq({tag, " exc"}, 32'(mul_if.data_exception), 32'(exp_exc));
    @(negedge clk);
    check_eq({tag, " rdy pulse"}, 32'(mul_if.data_resultRDY), 32'd0);
    check_eq({tag, " held"}, mul_if.data_result, exp_res);
  endtask

  initial begin
    int n;
    int pulses;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    mul_if.ctrl_MULT     = 1'b0;
    mul_if.data_operandA = '0;
    mul_if.data_operandB = '0;
    repeat (3) @(negedge clk);
    check_eq("reset result", mul_if.data_result, 32'd0);
    check_eq("reset flags", {28'd0, mul_if.data_exception, mul_if.data_resultRDY, mul_if.busy, 1'b0}, 32'd0);
    rst = 1'b0;

    do_mul("3*4",        32'd3,          32'd4,          32'h0000000C, 1'b0);
    do_mul("-7*6",       32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0);
    do_mul("min*-1",     32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1);
    do_mul("2^16*2^16",  32'h00010000,   32'h00010000,   32'h00000000, 1'b1);
    do_mul("min*min",    32'h80000000,   32'h80000000,   32'h00000000, 1'b1);
    do_mul("max*1",      32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 1'b0);
    do_mul("0*x",        32'd0,          32'h12345678,   32'h00000000, 1'b0);
    do_mul("-1*-1",      32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0);

    // Re-issue while running must be ignored.
    @(negedge clk);
    issue(32'd3, 32'd4);
    wait_rdy("repulse", 5, n);
    check_eq("repulse latency", 32'(n), 32'd17);
    check_eq("repulse result", mul_if.data_result, 32'd12);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_if.data_resultRDY) pulses++;
    end
    check_eq("repulse extra rdy", 32'(pulses), 32'd0);

    // Reset mid-operation aborts without a result pulse.
    @(negedge clk);
    issue(32'd7, 32'd7);
    repeat (8) begin
      @(negedge clk);
      mul_if.ctrl_MULT = 1'b0;
    end
    check_eq("abort busy before", 32'(mul_if.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort result", mul_if.data_result, 32'd0);
    check_eq("abort flags", {28'd0, mul_if.data_exception, mul_if.data_resultRDY, mul_if.busy, 1'b0}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mul_if.data_resultRDY) pulses++;
    end
    check_eq("abort no rdy", 32'(pulses), 32'd0);
    do_mul("2*-2", 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFC, 1'b0);

    // Back-to-back: new start raised during the DONE cycle.
    @(negedge clk);
    issue(32'd3, 32'd4);
    wait_rdy("b2b first", 0, n);
    check_eq("b2b first result", mul_if.data_result, 32'd12);
    issue(32'd9, 32'd9);
    wait_rdy("b2b second", 0, n);
    check_eq("b2b latency", 32'(n), 32'd17);
    check_eq("b2b result", mul_if.data_result, 32'h00000051);
    check_eq("b2b exc", 32'(mul_if.data_exception), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
